// File: rtl/enemy_sprite_drawer.sv
// enemy_sprite_drawer: turns enemy position updates into a VGA pixel stream.
// Each update erases the previous sprite rectangle in the background colour,
// then draws the new rectangle in the body or punch colour. One request may
// be queued while busy; it chains straight from DONE into ERASE.
module enemy_sprite_drawer #(
    parameter int       SPR_W        = 16,
    parameter int       SPR_H        = 24,
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter logic [2:0] BODY_COLOUR  = 3'b100,
    parameter logic [2:0] PUNCH_COLOUR = 3'b110
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       move,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic       punch,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_X = 5'(SPR_W - 1);
    localparam logic [4:0] LAST_Y = 5'(SPR_H - 1);

    state_t     state_r, state_s;
    logic [4:0] cx_r, cy_r;
    logic [7:0] new_x_r, old_x_r, pend_x_r;
    logic [6:0] new_y_r, old_y_r, pend_y_r;
    logic [2:0] new_col_r;
    logic       pend_punch_r;
    logic       first_r, pend_r;

    logic       scan_s, row_end_s, scan_end_s, chain_s;
    logic [7:0] base_x_s;
    logic [6:0] base_y_s;
    logic [8:0] sum_x_s;
    logic [7:0] sum_y_s;

    assign scan_s     = (state_r == ST_ERASE) || (state_r == ST_DRAW);
    assign row_end_s  = (cx_r == LAST_X);
    assign scan_end_s = row_end_s && (cy_r == LAST_Y);
    // A move arriving in the DONE cycle chains just like an already-queued one.
    assign chain_s    = (state_r == ST_DONE) && (pend_r || move);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (move) begin
                    state_s = first_r ? ST_DRAW : ST_ERASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ERASE: begin
                if (scan_end_s) begin
                    state_s = ST_DRAW;
                end else begin
                    state_s = ST_ERASE;
                end
            end
            ST_DRAW: begin
                if (scan_end_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAW;
                end
            end
            ST_DONE: begin
                if (chain_s) begin
                    state_s = ST_ERASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Scan counters, position/colour registers and the one-deep request queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cx_r         <= 5'd0;
            cy_r         <= 5'd0;
            new_x_r      <= 8'd0;
            new_y_r      <= 7'd0;
            new_col_r    <= 3'd0;
            old_x_r      <= 8'd0;
            old_y_r      <= 7'd0;
            pend_x_r     <= 8'd0;
            pend_y_r     <= 7'd0;
            pend_punch_r <= 1'b0;
            pend_r       <= 1'b0;
            first_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cx_r <= 5'd0;
                    cy_r <= 5'd0;
                    if (move) begin
                        new_x_r   <= x_in;
                        new_y_r   <= y_in;
                        new_col_r <= punch ? PUNCH_COLOUR : BODY_COLOUR;
                    end
                end
                ST_ERASE, ST_DRAW: begin
                    if (row_end_s) begin
                        cx_r <= 5'd0;
                        cy_r <= scan_end_s ? 5'd0 : cy_r + 5'd1;
                    end else begin
                        cx_r <= cx_r + 5'd1;
                    end
                    if (move) begin
                        pend_r       <= 1'b1;
                        pend_x_r     <= x_in;
                        pend_y_r     <= y_in;
                        pend_punch_r <= punch;
                    end
                end
                ST_DONE: begin
                    cx_r    <= 5'd0;
                    cy_r    <= 5'd0;
                    old_x_r <= new_x_r;
                    old_y_r <= new_y_r;
                    first_r <= 1'b0;
                    pend_r  <= 1'b0;
                    // Latest request wins: a move this cycle overrides the queue.
                    if (move) begin
                        new_x_r   <= x_in;
                        new_y_r   <= y_in;
                        new_col_r <= punch ? PUNCH_COLOUR : BODY_COLOUR;
                    end else if (pend_r) begin
                        new_x_r   <= pend_x_r;
                        new_y_r   <= pend_y_r;
                        new_col_r <= pend_punch_r ? PUNCH_COLOUR : BODY_COLOUR;
                    end
                end
                default: begin
                    cx_r <= 5'd0;
                    cy_r <= 5'd0;
                end
            endcase
        end
    end

    // Pixel decode: base + counter, clipped against the 160x120 screen.
    always_comb begin
        base_x_s   = 8'd0;
        base_y_s   = 7'd0;
        vga_colour = 3'd0;
        if (state_r == ST_ERASE) begin
            base_x_s   = old_x_r;
            base_y_s   = old_y_r;
            vga_colour = BG_COLOUR;
        end else if (state_r == ST_DRAW) begin
            base_x_s   = new_x_r;
            base_y_s   = new_y_r;
            vga_colour = new_col_r;
        end else begin
            base_x_s   = 8'd0;
            base_y_s   = 7'd0;
            vga_colour = 3'd0;
        end
        sum_x_s  = {1'b0, base_x_s} + {4'b0000, cx_r};
        sum_y_s  = {1'b0, base_y_s} + {3'b000, cy_r};
        vga_x    = scan_s ? sum_x_s[7:0] : 8'd0;
        vga_y    = scan_s ? sum_y_s[6:0] : 7'd0;
        vga_plot = scan_s && (sum_x_s < 9'd160) && (sum_y_s < 8'd120);
    end

    assign busy = (state_r != ST_IDLE);
    assign done = (state_r == ST_DONE);

endmodule

// File: tb/tb_enemy_sprite_drawer.sv
// Self-checking bench for enemy_sprite_drawer: table of sequential updates,
// then hand-written sequences for reset mid-scan, held move and queueing.
module tb_enemy_sprite_drawer;

    localparam int W = 16;
    localparam int H = 24;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       move = 1'b0;
    logic [7:0] x_in = 8'd0;
    logic [6:0] y_in = 7'd0;
    logic       punch = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    enemy_sprite_drawer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .move       (move),
        .x_in       (x_in),
        .y_in       (y_in),
        .punch      (punch),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       punch;
        bit         has_erase;
        int         ex;
        int         ey;
        int         exp_pe;
        int         exp_pd;
        int         exp_busy;
        logic [2:0] exp_col;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Start a one-cycle move pulse; returns at the first busy cycle's negedge.
    task automatic pulse(input logic [7:0] x, input logic [6:0] y, input logic p);
        move  = 1'b1;
        x_in  = x;
        y_in  = y;
        punch = p;
        @(negedge clock);
        move = 1'b0;
    endtask

    // Follow one update cycle by cycle against a raster-scan model.
    task automatic measure(input bit has_erase, input int ex, input int ey,
                           input int dx, input int dy, input logic [2:0] dcol,
                           output int pe, output int pd, output int bc,
                           output int dc, output int errs);
        int ne, ns, tot, idx, px, py;
        bit in_scan, ep;
        logic [2:0] ecol;
        pe = 0; pd = 0; bc = 0; dc = 0; errs = 0;
        ns  = W * H;
        ne  = has_erase ? ns : 0;
        tot = ne + ns + 1;
        for (int k = 0; k < tot; k++) begin
            in_scan = 1'b1;
            if (k < ne) begin
                idx = k;
                px = ex + idx % W; py = ey + idx / W; ecol = 3'b000;
            end else if (k < ne + ns) begin
                idx = k - ne;
                px = dx + idx % W; py = dy + idx / W; ecol = dcol;
            end else begin
                in_scan = 1'b0;
                px = 0; py = 0; ecol = 3'b000;
            end
            ep = in_scan && (px < 160) && (py < 120);
            if (busy === 1'b1) bc++;
            if (done === 1'b1) dc++;
            if (vga_plot === 1'b1) begin
                if (k < ne) pe++;
                else pd++;
            end
            if (vga_plot !== ep) errs++;
            else if (ep && (vga_x !== 8'(px) || vga_y !== 7'(py) || vga_colour !== ecol)) errs++;
            if (!in_scan && (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0)) errs++;
            if (done !== (k == tot - 1)) errs++;
            @(negedge clock);
        end
    endtask

    initial begin
        int pe, pd, bc, dc, errs;
        int pe2, pd2, bc2, dc2, errs2;

        vecs[0] = '{8'd20,  7'd8,   1'b0, 1'b0, 0,   0,   0,   384, 385, 3'b100};
        vecs[1] = '{8'd60,  7'd8,   1'b1, 1'b1, 20,  8,   384, 384, 769, 3'b110};
        vecs[2] = '{8'd150, 7'd100, 1'b0, 1'b1, 60,  8,   384, 200, 769, 3'b100};
        vecs[3] = '{8'd0,   7'd0,   1'b1, 1'b1, 150, 100, 200, 384, 769, 3'b110};

        // Reset state.
        @(negedge clock);
        check("reset_outputs", int'({busy, done, vga_plot, vga_x, vga_y, vga_colour}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", int'(busy), 0);

        // Table-driven updates, each depending on the previous one's position.
        for (int i = 0; i < 4; i++) begin
            pulse(vecs[i].x, vecs[i].y, vecs[i].punch);
            measure(vecs[i].has_erase, vecs[i].ex, vecs[i].ey, int'(vecs[i].x),
                    int'(vecs[i].y), vecs[i].exp_col, pe, pd, bc, dc, errs);
            check($sformatf("v%0d_pixels", i), errs, 0);
            check($sformatf("v%0d_erase_plots", i), pe, vecs[i].exp_pe);
            check($sformatf("v%0d_draw_plots", i), pd, vecs[i].exp_pd);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
            check($sformatf("v%0d_done_pulses", i), dc, 1);
            check($sformatf("v%0d_busy_after", i), int'(busy), 0);
        end

        // Reset in DRAW cycle 200: erase 384 cycles, then 200 draw cycles.
        pulse(8'd30, 7'd30, 1'b0);
        repeat (384 + 200) @(negedge clock);
        check("pre_reset_plot", int'(vga_plot), 1);
        check("pre_reset_x", int'(vga_x), 38);
        reset_n = 1'b0;
        #1;
        check("mid_reset_outputs", int'({busy, done, vga_plot, vga_x, vga_y, vga_colour}), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        pulse(8'd5, 7'd5, 1'b0);
        measure(1'b0, 0, 0, 5, 5, 3'b100, pe, pd, bc, dc, errs);
        check("post_reset_pixels", errs, 0);
        check("post_reset_erase_plots", pe, 0);
        check("post_reset_busy", bc, 385);

        // Held move for 3 cycles: one update plus one queued (last value wins).
        move = 1'b1; x_in = 8'd10; y_in = 7'd10; punch = 1'b0;
        @(negedge clock);
        fork
            measure(1'b1, 5, 5, 10, 10, 3'b100, pe, pd, bc, dc, errs);
            begin
                x_in = 8'd90;
                @(negedge clock);
                x_in = 8'd50; y_in = 7'd50;
                @(negedge clock);
                move = 1'b0;
            end
        join
        check("held_first_pixels", errs, 0);
        check("held_chain_no_idle", int'(busy), 1);
        measure(1'b1, 10, 10, 50, 50, 3'b100, pe2, pd2, bc2, dc2, errs2);
        check("held_chain_pixels", errs2, 0);
        check("held_done_total", dc + dc2, 2);
        check("held_busy_after", int'(busy), 0);

        // Two moves while busy: only the later one (x=60) is drawn next.
        pulse(8'd40, 7'd40, 1'b1);
        fork
            measure(1'b1, 50, 50, 40, 40, 3'b110, pe, pd, bc, dc, errs);
            begin
                repeat (20) @(negedge clock);
                pulse(8'd100, 7'd40, 1'b1);
                repeat (20) @(negedge clock);
                pulse(8'd60, 7'd40, 1'b0);
            end
        join
        check("queue_first_pixels", errs, 0);
        check("queue_chain_no_idle", int'(busy), 1);
        measure(1'b1, 40, 40, 60, 40, 3'b100, pe2, pd2, bc2, dc2, errs2);
        check("queue_chain_pixels", errs2, 0);
        check("queue_chain_draw_plots", pd2, 384);
        check("queue_chain_busy", bc2, 769);
        check("queue_single_chain", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_sprite_drawer.md
# enemy_sprite_drawer

Downstream of the enemy datapath. Consumes the enemy's x/y position, the `move` strobe and a punch flag, and turns each position update into a pixel stream for the VGA adapter (160x120, 3-bit colour). For each update it erases the previous sprite rectangle with the background colour, then draws the new rectangle in the body or punch colour. It reports `busy` and pulses `done` at the end of each update.

## Interface

Parameters:
- `SPR_W`, default 16: sprite width in pixels, 1..32.
- `SPR_H`, default 24: sprite height in pixels, 1..32.
- `BG_COLOUR`, default 3'b000: erase colour.
- `BODY_COLOUR`, default 3'b100: idle sprite colour.
- `PUNCH_COLOUR`, default 3'b110: sprite colour while punching.

Ports:
- `clock`, in, 1: system clock.
- `reset_n`, in, 1: reset; asynchronous, active-low.
- `move`, in, 1: update request, sampled each rising edge.
- `x_in`, in, 8: new sprite top-left x.
- `y_in`, in, 7: new sprite top-left y.
- `punch`, in, 1: draw in `PUNCH_COLOUR` instead of `BODY_COLOUR`.
- `vga_x`, out, 8: pixel x to adapter.
- `vga_y`, out, 7: pixel y to adapter.
- `vga_colour`, out, 3: pixel colour.
- `vga_plot`, out, 1: write enable to adapter, one pixel per cycle.
- `busy`, out, 1: high in ERASE, DRAW and DONE.
- `done`, out, 1: single-cycle pulse at the end of an update.

## Operation

**State machine.** States are IDLE, ERASE, DRAW and DONE.
- **IDLE.** If `move`=1, capture `x_in`, `y_in` and `punch` into `new_x`, `new_y` and `new_col`. Clear `cx` and `cy`.
  - Next state is DRAW if `first`=1, otherwise ERASE.
- **ERASE.** Scan the rectangle at `old_x`, `old_y` with `BG_COLOUR`.
  - Raster order: `cx` is the inner loop (0..SPR_W-1), `cy` is the outer loop (0..SPR_H-1).
  - After pixel (SPR_W-1, SPR_H-1), clear the counters and go to DRAW.
- **DRAW.** Same scan at `new_x`, `new_y` with `new_col`. After the last pixel, go to DONE.
- **DONE.** Copy `new_x`/`new_y` into `old_x`/`old_y`. Clear `first` and assert `done`.
  - If `pend`=1, load the pending registers into the new registers, clear `pend` and go to ERASE.
  - Otherwise go to IDLE.

**Output decode.** `vga_x`/`vga_y` are the base position plus `cx`/`cy`, computed at 9/8 bits and truncated to 8/7 bits.
- `vga_plot` = (state is ERASE or DRAW) AND sum_x < 160 AND sum_y < 120.
- Off-screen pixels are suppressed, but the counters still advance, so scan length is fixed.
- `vga_colour` is `BG_COLOUR` in ERASE and `new_col` in DRAW.
- All `vga_*` outputs are combinational decode of the state, counters and position registers. Outside ERASE/DRAW they are 0.

**Pending request.** A `move` seen while `busy`=1 sets `pend` and captures `x_in`, `y_in` and `punch` into the pending registers.
- Last request wins; only one update is queued.
- A `move` in the DONE cycle also counts as pending.

**Reset.** Asserting `reset_n` low at any time, including mid-scan, forces:
- state IDLE, `first`=1, `pend`=0;
- counters, position and colour registers to 0;
- every output to 0.

The partially drawn frame is not repaired.

## Timing

- A `move` sampled at edge E0 makes the state ERASE (or DRAW on the first update) for the cycle after E0. `vga_plot` is valid in that cycle, so latency is 1 cycle.
- One pixel per cycle, with no back-pressure from the adapter.
- Busy duration:
  - normal update: 2·SPR_W·SPR_H + 1 cycles;
  - first update after reset: SPR_W·SPR_H + 1 cycles.
- `done` is high for exactly the DONE cycle. `busy` falls on the following edge unless a pending update chains.
- A chained update re-enters ERASE directly after DONE with no IDLE cycle.
- `move` held high for several cycles while IDLE starts one update, then queues at most one more.

## Test plan

- **First update after reset:** reset, then `move` with x=20, y=8, punch=0. Required: no ERASE; 384 plots in DRAW with colour 3'b100, covering x 20..35 and y 8..31 in raster order; `done` at cycle 385; `busy` high for 385 cycles.
- **Erase then draw:** after the first update, `move` with x=60, y=8, punch=1. Required: 384 plots at x 20..35 with colour 3'b000, then 384 plots at x 60..75 with colour 3'b110; total busy 769 cycles.
- **Clipping:** `move` with x=150, y=100. Required: DRAW plots only x 150..159 and y 100..119 (200 pixels); the scan still takes 384 cycles; `vga_plot` is low for the 184 off-screen pixels.
- **Queued requests:** two `move` pulses during busy, at x=100 then x=60. Required: exactly one chained update, targeting x=60; ERASE starts the cycle after `done`; no IDLE cycle in between.
- **Reset mid-scan:** drop `reset_n` in cycle 200 of DRAW. Required: all outputs 0 immediately. The next `move` behaves as a first update, with no ERASE.
- **Held `move`:** hold `move` high for 3 cycles in IDLE. Required: one update plus one pending update, with 2 `done` pulses in total.
